// File: rtl/digit_serial_add_sub.sv
// Digit-serial adder/subtractor: a+b+cin or a-b-cin over WIDTH bits, DIGIT bits per clock.
// Latency: out_valid rises exactly N=WIDTH/DIGIT edges after the accept edge; one op per N+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, in_valid ignored meanwhile.
module digit_serial_add_sub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int N  = WIDTH / DIGIT;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [WIDTH-1:0] DIG_MASK  = WIDTH'({DIGIT{1'b1}});
    localparam logic [KW-1:0]    K_LAST    = KW'(N - 1);

    // Reject parameter sets that do not split into whole digits.
    if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
        $error("digit_serial_add_sub: WIDTH must be a multiple of DIGIT with 1 <= DIGIT <= WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;     // already inverted for subtract
    logic             carry_q, carry_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Single reused full-add stage working on digit k.
    int               shift;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;
    logic [DIGIT:0]   dig_full;
    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             carry_into_msb;

    // Select the current digit of both operands and add it with the held ripple carry.
    always_comb begin
        shift          = int'(k_q) * DIGIT;
        a_dig          = DIGIT'(a_q >> shift);
        b_dig          = DIGIT'(b_q >> shift);
        dig_full       = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
        dig_sum        = dig_full[DIGIT-1:0];
        dig_cout       = dig_full[DIGIT];
        // Carry into the digit MSB recovered from its sum bit: s = a ^ b ^ c_in.
        carry_into_msb = dig_sum[DIGIT-1] ^ a_dig[DIGIT-1] ^ b_dig[DIGIT-1];
    end

    // Next-state logic: accept in IDLE, ripple one digit per cycle in RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        k_d     = k_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = op ? ~b : b;
                    carry_d = op ? ~cin : cin;
                    k_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d   = (sum_q & ~(DIG_MASK << shift)) | (WIDTH'(dig_sum) << shift);
                carry_d = dig_cout;
                if (k_q == K_LAST) begin
                    cout_d  = dig_cout;
                    ovf_d   = dig_cout ^ carry_into_msb;
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            k_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            k_q     <= k_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
